// File: rtl/pwm_button_conditioner.sv
// ---------------------------------------------------------------------------
// pwm_button_conditioner
//   Turns two raw, bouncing push buttons (increase / decrease) into clean
//   one-cycle step requests and debounced level outputs for a PWM duty
//   controller. Each button has its own 2-flop synchronizer and a
//   IDLE / PRESS_CHK / HELD / REL_CHK debounce FSM with a 16-bit counter.
//
//   Optional feature: define PWM_BTN_AUTO_REPEAT_EN to add auto-repeat while
//   a button is held (first repeat REPEAT_DELAY cycles after the accepted
//   press, then every REPEAT_PERIOD cycles). Without the macro, each accepted
//   press yields exactly one pulse and no repeat counter exists.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   block enable; low forces both FSMs idle, outputs low
//   btn_inc_i    in   raw increase button (high = pressed)
//   btn_dec_i    in   raw decrease button (high = pressed)
//   inc_pulse_o  out  one-cycle raise-duty request
//   dec_pulse_o  out  one-cycle lower-duty request
//   inc_level_o  out  debounced increase button level
//   dec_level_o  out  debounced decrease button level
//   dbg_state    out  FSM states for observation: [1:0] inc, [3:2] dec
//
// Handshake: the pulse outputs are fire-and-forget strobes (no ready);
// the consumer must sample them on every rising edge.
// ---------------------------------------------------------------------------
module pwm_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       btn_inc_i,
   input  logic       btn_dec_i,
   output logic       inc_pulse_o,
   output logic       dec_pulse_o,
   output logic       inc_level_o,
   output logic       dec_level_o,
   output logic [3:0] dbg_state
);

   // Elaboration-time range checks on the configuration.
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 1..65535");
   end
   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535) begin : g_bad_delay
      $error("REPEAT_DELAY out of range 1..65535");
   end
   if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_period
      $error("REPEAT_PERIOD out of range 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } btn_state_t;

   localparam logic [15:0] DEB = 16'(DEBOUNCE_CYCLES);

   // Index 0 = increase button, index 1 = decrease button.
   logic [1:0]  sync1_q, sync2_q;
   btn_state_t  state_q [2];
   btn_state_t  state_d [2];
   logic [15:0] cnt_q   [2];
   logic [15:0] cnt_d   [2];
   logic [1:0]  lvl_q, lvl_d;
   logic [1:0]  fire;
   logic [1:0]  pulse_q, pulse_d;

`ifdef PWM_BTN_AUTO_REPEAT_EN
   localparam logic [15:0] RPT_DLY = 16'(REPEAT_DELAY);
   localparam logic [15:0] RPT_PER = 16'(REPEAT_PERIOD);
   logic [15:0] rpt_q [2];
   logic [15:0] rpt_d [2];
   logic [1:0]  first_q, first_d;   // first repeat already issued
   logic [15:0] rpt_inc;
`endif

   always_comb begin
`ifdef PWM_BTN_AUTO_REPEAT_EN
      rpt_inc = '0;
      first_d = first_q;
`endif
      lvl_d = lvl_q;
      fire  = '0;
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef PWM_BTN_AUTO_REPEAT_EN
         rpt_d[i]   = rpt_q[i];
`endif
         if (!ena) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            lvl_d[i]   = 1'b0;
`ifdef PWM_BTN_AUTO_REPEAT_EN
            rpt_d[i]   = '0;
            first_d[i] = 1'b0;
`endif
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (sync2_q[i]) begin
                     state_d[i] = PRESS_CHK;
                     cnt_d[i]   = 16'd1;
                  end
               end
               PRESS_CHK: begin
                  if (!sync2_q[i]) begin
                     state_d[i] = IDLE;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == DEB) begin
                     state_d[i] = HELD;
                     cnt_d[i]   = '0;
                     lvl_d[i]   = 1'b1;
                     fire[i]    = 1'b1;
`ifdef PWM_BTN_AUTO_REPEAT_EN
                     rpt_d[i]   = '0;
                     first_d[i] = 1'b0;
`endif
                  end else if (cnt_q[i] != 16'hFFFF) begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
               HELD: begin
                  if (!sync2_q[i]) begin
                     state_d[i] = REL_CHK;
                     cnt_d[i]   = 16'd1;
                  end
`ifdef PWM_BTN_AUTO_REPEAT_EN
                  else begin
                     rpt_inc  = (rpt_q[i] == 16'hFFFF) ? rpt_q[i] : rpt_q[i] + 16'd1;
                     rpt_d[i] = rpt_inc;
                     if (!first_q[i] && rpt_inc == RPT_DLY) begin
                        fire[i]    = 1'b1;
                        first_d[i] = 1'b1;
                        rpt_d[i]   = '0;
                     end else if (first_q[i] && rpt_inc == RPT_PER) begin
                        fire[i]  = 1'b1;
                        rpt_d[i] = '0;
                     end
                  end
`endif
               end
               REL_CHK: begin
                  // Repeat counter intentionally untouched here: a release
                  // bounce freezes the repeat schedule instead of restarting it.
                  if (sync2_q[i]) begin
                     state_d[i] = HELD;
                     cnt_d[i]   = '0;
                  end else if (cnt_q[i] == DEB) begin
                     state_d[i] = IDLE;
                     cnt_d[i]   = '0;
                     lvl_d[i]   = 1'b0;
                  end else if (cnt_q[i] != 16'hFFFF) begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
               default: begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
      // Simultaneous requests cancel each other; a pulse is also blocked
      // right after another pulse so strobes never stretch to two cycles.
      pulse_d[0] = fire[0] & ~fire[1] & ~pulse_q[0];
      pulse_d[1] = fire[1] & ~fire[0] & ~pulse_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         pulse_q <= '0;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         // Synchronizers keep running even while ena is low.
         sync1_q <= {btn_dec_i, btn_inc_i};
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         pulse_q <= pulse_d;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef PWM_BTN_AUTO_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= '0;
         for (int i = 0; i < 2; i++) rpt_q[i] <= '0;
      end else begin
         first_q <= first_d;
         for (int i = 0; i < 2; i++) rpt_q[i] <= rpt_d[i];
      end
   end
`endif

   assign inc_pulse_o = pulse_q[0];
   assign dec_pulse_o = pulse_q[1];
   assign inc_level_o = lvl_q[0];
   assign dec_level_o = lvl_q[1];
   assign dbg_state   = {state_q[1], state_q[0]};

endmodule

// File: doc/pwm_button_conditioner.md
PWM_BUTTON_CONDITIONER -- requirements
Module: pwm_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before a press or release is accepted; legal range 1..65535.
REQ-002 Parameter REPEAT_DELAY, default 16: cycles a button stays held after the accepted press before the first auto-repeat pulse; legal range 1..65535.
REQ-003 Parameter REPEAT_PERIOD, default 8: cycles between subsequent auto-repeat pulses; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  block enable; low forces idle.
REQ-007 btn_inc_i  input  1  raw, asynchronous, bouncing increase button; high = pressed.
REQ-008 btn_dec_i  input  1  raw, asynchronous, bouncing decrease button; high = pressed.
REQ-009 inc_pulse_o  output  1  registered one-cycle request to raise duty one step.
REQ-010 dec_pulse_o  output  1  registered one-cycle request to lower duty one step.
REQ-011 inc_level_o  output  1  registered debounced level of the increase button.
REQ-012 dec_level_o  output  1  registered debounced level of the decrease button.

Function
REQ-013 Each raw button passes through a 2-flop synchronizer; all logic below uses only synchronized values.
REQ-014 Each button has an independent FSM with states IDLE, PRESS_CHK, HELD, REL_CHK and a 16-bit counter.
REQ-015 IDLE: synchronized high -> PRESS_CHK with counter = 1.
REQ-016 PRESS_CHK: synchronized low -> IDLE; high with counter = DEBOUNCE_CYCLES -> HELD, level_o set, one pulse_o; otherwise counter increments.
REQ-017 HELD: synchronized low -> REL_CHK with counter = 1; otherwise the repeat logic in REQ-026 applies.
REQ-018 REL_CHK: synchronized high -> HELD without a pulse; low with counter = DEBOUNCE_CYCLES -> IDLE, level_o cleared; otherwise counter increments.
REQ-019 With DEBOUNCE_CYCLES=4, a clean press aligned before rising edge N produces pulse_o high during cycle N+6 only.
REQ-020 Bouncing inputs (glitches shorter than DEBOUNCE_CYCLES) never produce a pulse or a level change.
REQ-021 Conflict: if both FSMs would emit a pulse in the same cycle, both pulses are suppressed; level outputs still update.
REQ-022 Pulse outputs are never high for two consecutive cycles.
REQ-023 ena low: both FSMs forced to IDLE, counters cleared, all four outputs low the next cycle; synchronizers keep running.
REQ-024 Counters saturate and never wrap.

Reset
REQ-025 rst_n low immediately clears the synchronizers, forces both FSMs to IDLE, clears counters, and drives all four outputs to 0; first press evaluation starts on the first rising edge after rst_n is released.

Configuration
REQ-026 Macro PWM_BTN_AUTO_REPEAT_EN defined: in HELD, a repeat counter issues one pulse_o when a button has been held REPEAT_DELAY cycles after the accepted press, then one every REPEAT_PERIOD cycles; the counter restarts on entry to HELD from PRESS_CHK and freezes (does not reset) during REL_CHK bounces.
REQ-027 Macro undefined: exactly one pulse per accepted press; REPEAT_DELAY and REPEAT_PERIOD are ignored; no repeat counter is instantiated.

Verification
REQ-028 DEBOUNCE_CYCLES=4; btn_inc_i rises before edge 0 and stays high -> inc_pulse_o high in cycle 6 only, inc_level_o high from cycle 6.
REQ-029 btn_dec_i toggles 1,0,1,0 each cycle for 10 cycles, then stays low -> dec_pulse_o and dec_level_o remain 0.
REQ-030 Both buttons rise in the same cycle and are held -> no pulses at all, both levels high after 6 cycles.
REQ-031 Macro PWM_BTN_AUTO_REPEAT_EN defined, DELAY=16, PERIOD=8; inc held 50 cycles after accepted press -> pulses at +0, +16, +24, +32, +40, +48.
REQ-032 rst_n pulled low mid-PRESS_CHK (counter=2) -> outputs 0 immediately; after release, a fresh press is accepted only after the full 6-cycle latency.
REQ-033 ena dropped while inc held in HELD -> inc_level_o 0 next cycle; ena re-raised with button still held -> new pulse 4 cycles later.
